// File: rtl/feature_extractor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : feature_extractor_sequencer
// Purpose  : Frame-level controller in front of Feature_Extractor. Accepts a
//            host frame request, pulses the extractor start, streams exactly
//            IMG_WIDTH*IMG_HEIGHT pixels from a ready/valid source, forwards
//            and indexes pooled results, and closes the frame on extractor
//            done, abort, or (optionally) a DRAIN watchdog timeout.
// Options  : FE_SEQ_TIMEOUT_EN - when defined, a DRAIN watchdog forces the
//            frame closed after TIMEOUT_CYCLES; otherwise err_timeout is 0.
// Ports    : clk, rst (sync, active-low)
//            frame_req, abort            host control pulses
//            src_valid/src_pixel/src_ready  pixel source handshake
//            fe_start/fe_pixel_valid/fe_pixel  to extractor
//            fe_result/fe_result_valid/fe_done from extractor
//            res_out/res_valid/res_idx   registered, indexed results
//            busy, frame_done, err_count, err_timeout, err_abort  status
// Revision : 1.0 - initial release
// ============================================================================
module feature_extractor_sequencer #(
    parameter int IMG_WIDTH      = 32,
    parameter int IMG_HEIGHT     = 32,
    parameter int RES_W          = 22,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         frame_req,
    input  logic                                         abort,
    input  logic                                         src_valid,
    input  logic [7:0]                                   src_pixel,
    output logic                                         src_ready,
    output logic                                         fe_start,
    output logic                                         fe_pixel_valid,
    output logic [7:0]                                   fe_pixel,
    input  logic signed [RES_W-1:0]                      fe_result,
    input  logic                                         fe_result_valid,
    input  logic                                         fe_done,
    output logic signed [RES_W-1:0]                      res_out,
    output logic                                         res_valid,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT/4)-1:0]    res_idx,
    output logic                                         busy,
    output logic                                         frame_done,
    output logic                                         err_count,
    output logic                                         err_timeout,
    output logic                                         err_abort
);

    localparam int c_NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int c_NUM_RES = c_NUM_PIX / 4;
    localparam int c_IDX_W   = $clog2(c_NUM_RES);
    // Counters are wide enough to hold the full pixel count; the result
    // counter saturates so an over-producing extractor still flags an error.
    localparam int c_CNT_W   = $clog2(c_NUM_PIX + 1);

    localparam logic [c_CNT_W-1:0] c_PIX_TARGET = c_CNT_W'(c_NUM_PIX);
    localparam logic [c_CNT_W-1:0] c_RES_TARGET = c_CNT_W'(c_NUM_RES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    generate
        if ((IMG_WIDTH % 2) != 0 || (IMG_HEIGHT % 2) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("feature_extractor_sequencer: image dimensions must be even and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_CLOSE  = 3'd4
    } state_t;

    state_t                    r_state;
    logic                      r_src_ready;
    logic                      r_fe_start;
    logic                      r_fe_pixel_valid;
    logic [7:0]                r_fe_pixel;
    logic signed [RES_W-1:0]   r_res_out;
    logic                      r_res_valid;
    logic [c_IDX_W-1:0]        r_res_idx;
    logic                      r_busy;
    logic                      r_frame_done;
    logic                      r_err_count;
    logic                      r_err_abort;
    logic [c_CNT_W-1:0]        r_pix_cnt;
    logic [c_CNT_W-1:0]        r_res_cnt;

`ifdef FE_SEQ_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_TIMEOUT = c_WD_W'(TIMEOUT_CYCLES);
    logic [c_WD_W-1:0]            r_wd;
    logic                         r_err_timeout;
`endif

    logic                 w_active;
    logic                 w_beat;
    logic                 w_res_take;
    logic [c_CNT_W-1:0]   w_pix_cnt_nxt;
    logic [c_CNT_W-1:0]   w_res_cnt_nxt;
    logic                 w_close_abort;
    logic                 w_close_done;
    logic                 w_close_timeout;
    logic                 w_close;
    logic                 w_count_bad;

    always_comb begin
        w_active      = (r_state == S_START) || (r_state == S_STREAM) || (r_state == S_DRAIN);
        w_beat        = r_src_ready & src_valid;
        w_pix_cnt_nxt = r_pix_cnt + c_CNT_W'(w_beat);
        w_res_take    = w_active & fe_result_valid;
        w_res_cnt_nxt = (w_res_take && (r_res_cnt != c_CNT_MAX)) ? (r_res_cnt + c_CNT_ONE) : r_res_cnt;
        w_close_abort = w_active & abort;
        w_close_done  = w_active & fe_done;
`ifdef FE_SEQ_TIMEOUT_EN
        w_close_timeout = (r_state == S_DRAIN) && (r_wd == c_TIMEOUT);
`else
        w_close_timeout = 1'b0;
`endif
        w_close       = w_close_abort | w_close_done | w_close_timeout;
        // Uses next-state counts so a result or pixel landing in the closing
        // cycle is included in the check.
        w_count_bad   = (w_res_cnt_nxt != c_RES_TARGET) || (w_pix_cnt_nxt != c_PIX_TARGET);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_src_ready      <= 1'b0;
            r_fe_start       <= 1'b0;
            r_fe_pixel_valid <= 1'b0;
            r_fe_pixel       <= '0;
            r_res_out        <= '0;
            r_res_valid      <= 1'b0;
            r_res_idx        <= '0;
            r_busy           <= 1'b0;
            r_frame_done     <= 1'b0;
            r_err_count      <= 1'b0;
            r_err_abort      <= 1'b0;
            r_pix_cnt        <= '0;
            r_res_cnt        <= '0;
`ifdef FE_SEQ_TIMEOUT_EN
            r_wd             <= '0;
            r_err_timeout    <= 1'b0;
`endif
        end else begin
            r_fe_start   <= 1'b0;
            r_frame_done <= 1'b0;

            // Pixel path: one-cycle registered forward, gaps pass through.
            r_fe_pixel_valid <= w_beat;
            if (w_beat) begin
                r_fe_pixel <= src_pixel;
            end

            // Result path: index is the count before this result.
            r_res_valid <= w_res_take;
            if (w_res_take) begin
                r_res_out <= fe_result;
                r_res_idx <= r_res_cnt[c_IDX_W-1:0];
            end

            r_pix_cnt <= w_pix_cnt_nxt;
            r_res_cnt <= w_res_cnt_nxt;

            if (w_close) begin
                // Abort outranks done, which outranks the watchdog.
                r_state      <= S_CLOSE;
                r_frame_done <= 1'b1;
                r_busy       <= 1'b0;
                r_src_ready  <= 1'b0;
                r_err_count  <= w_count_bad;
                r_err_abort  <= w_close_abort;
`ifdef FE_SEQ_TIMEOUT_EN
                r_err_timeout <= w_close_timeout & ~w_close_abort & ~w_close_done;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (frame_req) begin
                            r_state     <= S_START;
                            r_fe_start  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_pix_cnt   <= '0;
                            r_res_cnt   <= '0;
                            r_err_count <= 1'b0;
                            r_err_abort <= 1'b0;
`ifdef FE_SEQ_TIMEOUT_EN
                            r_err_timeout <= 1'b0;
                            r_wd          <= '0;
`endif
                        end
                    end
                    S_START: begin
                        r_state     <= S_STREAM;
                        r_src_ready <= 1'b1;
                    end
                    S_STREAM: begin
                        if (w_beat && (w_pix_cnt_nxt == c_PIX_TARGET)) begin
                            r_state     <= S_DRAIN;
                            r_src_ready <= 1'b0;
`ifdef FE_SEQ_TIMEOUT_EN
                            r_wd        <= '0;
`endif
                        end
                    end
                    S_DRAIN: begin
`ifdef FE_SEQ_TIMEOUT_EN
                        r_wd <= r_wd + c_WD_W'(1);
`endif
                    end
                    S_CLOSE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign src_ready      = r_src_ready;
    assign fe_start       = r_fe_start;
    assign fe_pixel_valid = r_fe_pixel_valid;
    assign fe_pixel       = r_fe_pixel;
    assign res_out        = r_res_out;
    assign res_valid      = r_res_valid;
    assign res_idx        = r_res_idx;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
    assign err_count      = r_err_count;
    assign err_abort      = r_err_abort;
`ifdef FE_SEQ_TIMEOUT_EN
    assign err_timeout    = r_err_timeout;
`else
    assign err_timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_feature_extractor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_extractor_sequencer
// Purpose  : Directed self-checking bench for feature_extractor_sequencer.
//            The bench plays host, pixel source and extractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_feature_extractor_sequencer;

    localparam int c_W    = 32;
    localparam int c_H    = 32;
    localparam int c_RW   = 22;
    localparam int c_T    = 4096;
    localparam int c_NPIX = c_W * c_H;
    localparam int c_NRES = c_NPIX / 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   frame_req = 1'b0;
    logic                   abort = 1'b0;
    logic                   src_valid = 1'b0;
    logic [7:0]             src_pixel = '0;
    logic                   src_ready;
    logic                   fe_start;
    logic                   fe_pixel_valid;
    logic [7:0]             fe_pixel;
    logic signed [c_RW-1:0] fe_result = '0;
    logic                   fe_result_valid = 1'b0;
    logic                   fe_done = 1'b0;
    logic signed [c_RW-1:0] res_out;
    logic                   res_valid;
    logic [7:0]             res_idx;
    logic                   busy;
    logic                   frame_done;
    logic                   err_count;
    logic                   err_timeout;
    logic                   err_abort;

    feature_extractor_sequencer #(
        .IMG_WIDTH      (c_W),
        .IMG_HEIGHT     (c_H),
        .RES_W          (c_RW),
        .TIMEOUT_CYCLES (c_T)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .frame_req       (frame_req),
        .abort           (abort),
        .src_valid       (src_valid),
        .src_pixel       (src_pixel),
        .src_ready       (src_ready),
        .fe_start        (fe_start),
        .fe_pixel_valid  (fe_pixel_valid),
        .fe_pixel        (fe_pixel),
        .fe_result       (fe_result),
        .fe_result_valid (fe_result_valid),
        .fe_done         (fe_done),
        .res_out         (res_out),
        .res_valid       (res_valid),
        .res_idx         (res_idx),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_count       (err_count),
        .err_timeout     (err_timeout),
        .err_abort       (err_abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_start, n_pix, n_resv, pix_err, res_err, n_fd, first_pix_cyc, fd_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [c_RW-1:0] res_val(input int k);
        return c_RW'(k * 1531 - 200000);
    endfunction

    // Advance one clock and observe outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (fe_start) n_start++;
        if (fe_pixel_valid) begin
            if (n_pix == 0) first_pix_cyc = cyc;
            if (fe_pixel != 8'(n_pix)) pix_err++;
            n_pix++;
        end
        if (res_valid) begin
            if (res_idx != 8'(n_resv) || res_out != res_val(n_resv)) res_err++;
            n_resv++;
        end
        if (frame_done) begin
            n_fd++;
            fd_cyc = cyc;
        end
    endtask

    task automatic clear_mon();
        n_start = 0; n_pix = 0; n_resv = 0; pix_err = 0; res_err = 0;
        n_fd = 0; first_pix_cyc = 0; fd_cyc = 0;
    endtask

    task automatic start_frame(output int req_cyc);
        clear_mon();
        req_cyc   = cyc;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check_val("fe_start_n1", fe_start, 1);
        check_val("err_clr_on_req", {err_count, err_timeout, err_abort}, 0);
        tick();
        check_val("src_ready_n2", {src_ready, fe_start}, 2'b10);
    endtask

    // gap=1 toggles src_valid every cycle; req_at pulses frame_req on that loop cycle.
    task automatic stream(input int gap, input int stop_at, input int req_at, output int sent);
        int g;
        logic hs;
        sent = 0;
        g    = 0;
        while (sent < stop_at && g < 5000) begin
            src_valid = (gap == 0) ? 1'b1 : ((g % 2) == 0);
            src_pixel = 8'(sent);
            frame_req = (g == req_at);
            hs = src_valid && src_ready;
            tick();
            if (hs) sent++;
            g++;
        end
        src_valid = 1'b0;
        frame_req = 1'b0;
        check_val("stream_sent", sent, stop_at);
    endtask

    // Returns n results back to back; fe_done rides with the last one.
    task automatic finish(input int n);
        for (int k = 0; k < n; k++) begin
            fe_result_valid = 1'b1;
            fe_result       = res_val(k);
            fe_done         = (k == n - 1);
            tick();
            if (k == 0) check_val("res_latency", res_valid, 1);
        end
        fe_result_valid = 1'b0;
        fe_done         = 1'b0;
    endtask

    task automatic nominal_frame(input string tag);
        int rq, sent;
        start_frame(rq);
        stream(0, c_NPIX, -1, sent);
        check_val({tag, "_src_ready_drop"}, src_ready, 0);
        check_val({tag, "_first_pix_lat"}, first_pix_cyc - rq, 3);
        check_val({tag, "_pix_cnt"}, n_pix, c_NPIX);
        check_val({tag, "_pix_order"}, pix_err, 0);
        tick();
        finish(c_NRES);
        check_val({tag, "_frame_done"}, frame_done, 1);
        check_val({tag, "_flags"}, {err_count, err_timeout, err_abort}, 0);
        tick();
        check_val({tag, "_busy_m2"}, {busy, frame_done}, 0);
        check_val({tag, "_start_pulses"}, n_start, 1);
        check_val({tag, "_res_cnt"}, n_resv, c_NRES);
        check_val({tag, "_res_order"}, res_err, 0);
        check_val({tag, "_fd_pulses"}, n_fd, 1);
    endtask

    initial begin
        int rq, sent, d, g;

        // Reset state
        clear_mon();
        rst = 1'b0;
        repeat (3) tick();
        check_val("rst_outs", {src_ready, fe_start, fe_pixel_valid, busy, frame_done,
                               err_count, err_timeout, err_abort, res_valid}, 0);
        check_val("rst_data", {fe_pixel, res_idx}, 0);
        check_val("rst_res_out", 32'(res_out), 0);
        rst = 1'b1;
        tick();

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check_val("idle_abort", {busy, frame_done, err_abort}, 0);

        // Nominal frame, last result coincident with fe_done
        nominal_frame("nom");

        // Source gaps, frame_req while busy, short result count
        start_frame(rq);
        stream(1, c_NPIX, 300, sent);
        check_val("gap_pix_cnt", n_pix, c_NPIX);
        check_val("gap_pix_order", pix_err, 0);
        check_val("gap_src_ready_drop", src_ready, 0);
        finish(c_NRES - 1);
        check_val("short_frame_done", frame_done, 1);
        check_val("short_err_count", err_count, 1);
        repeat (4) tick();
        check_val("short_err_hold", err_count, 1);
        check_val("busy_req_ignored", n_start, 1);
        check_val("short_res_cnt", n_resv, c_NRES - 1);

        // Watchdog
        start_frame(rq);
        stream(0, c_NPIX, -1, sent);
        d = cyc;
`ifdef FE_SEQ_TIMEOUT_EN
        g = 0;
        while (!frame_done && g < c_T + 100) begin
            tick();
            g++;
        end
        check_val("to_frame_done", frame_done, 1);
        check_val("to_latency", fd_cyc - d, c_T + 1);
        check_val("to_flags", {err_timeout, err_abort}, 2'b10);
        tick();
`else
        g = 0;
        repeat (c_T + 200) tick();
        check_val("nowd_busy", busy, 1);
        check_val("nowd_no_done", n_fd, g);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("nowd_abort", {frame_done, err_abort, err_timeout}, 3'b110);
        tick();
`endif

        // Abort during STREAM at pixel 500
        start_frame(rq);
        stream(0, 500, -1, sent);
        check_val("ab_still_ready", src_ready, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("ab_src_ready", src_ready, 0);
        check_val("ab_flags", {frame_done, err_abort, err_timeout}, 3'b110);
        check_val("ab_pix_cnt", n_pix, 500);
        tick();
        check_val("ab_busy", busy, 0);
        nominal_frame("post_ab");

        // Reset mid-DRAIN
        start_frame(rq);
        stream(0, c_NPIX, -1, sent);
        repeat (10) tick();
        check_val("drain_busy", busy, 1);
        rst = 1'b0;
        tick();
        check_val("mid_rst_outs", {src_ready, fe_start, fe_pixel_valid, busy, frame_done,
                                   err_count, err_timeout, err_abort, res_valid}, 0);
        rst = 1'b1;
        repeat (3) tick();
        check_val("mid_rst_no_fd", n_fd, 0);
        check_val("mid_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
